// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
//   Expands one LM/SM instruction from decode into one register/memory
//   micro-op per cycle. Registers are visited in ascending order at
//   consecutive word addresses starting at the base address. Upstream
//   stages are stalled while the expansion runs.
//
// Ports
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   instr_valid_i       decode presents an instruction
//   op_i                opcode (4'b0110 LM, 4'b0111 SM)
//   reg_mask_i          bit i set = transfer Ri
//   base_addr_i         start address (RA value)
//   hold_i              downstream stall, freezes the sequencer
//   flush_i             kill the in-flight instruction
//   stall_out_o         hold fetch/decode
//   uop_valid_o         micro-op issued this cycle
//   reg_addr_o          register index of the micro-op
//   mem_addr_o          memory address of the micro-op
//   reg_write_o         register-file write request (LM)
//   mem_write_o         memory write request (SM)
//   done_o              LM/SM retires this cycle
module lm_sm_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              instr_valid_i,
    input  logic [3:0]        op_i,
    input  logic [7:0]        reg_mask_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              stall_out_o,
    output logic              uop_valid_o,
    output logic [2:0]        reg_addr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              reg_write_o,
    output logic              mem_write_o,
    output logic              done_o
);

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q, state_d;
    logic [7:0]        rem_mask_q, rem_mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_lm_q, is_lm_d;

    logic [2:0] low_idx;
    logic [7:0] low_bit;
    logic       last;
    logic       start;
    logic       issue;

    // Lowest set bit of the remaining mask; scanning downward lets the
    // lowest index overwrite higher ones.
    always_comb begin
        low_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (rem_mask_q[i]) low_idx = 3'(i);
        end
    end

    assign low_bit = 8'b1 << low_idx;
    assign last    = (rem_mask_q & ~low_bit) == 8'h00;
    assign start   = (state_q == IDLE) & instr_valid_i &
                     ((op_i == OP_LM) | (op_i == OP_SM)) & !hold_i & !flush_i;
    assign issue   = (state_q == RUN) & !hold_i & !flush_i;

    always_comb begin
        state_d     = state_q;
        rem_mask_d  = rem_mask_q;
        addr_d      = addr_q;
        is_lm_d     = is_lm_q;
        stall_out_o = 1'b0;
        uop_valid_o = 1'b0;
        reg_addr_o  = '0;
        mem_addr_o  = '0;
        reg_write_o = 1'b0;
        mem_write_o = 1'b0;
        done_o      = 1'b0;

        if (state_q == IDLE) begin
            if (start) begin
                if (reg_mask_i != 8'h00) begin
                    rem_mask_d  = reg_mask_i;
                    addr_d      = base_addr_i;
                    is_lm_d     = (op_i == OP_LM);
                    state_d     = RUN;
                    stall_out_o = 1'b1;
                end else begin
                    // Empty mask retires immediately without occupying RUN.
                    done_o = 1'b1;
                end
            end
        end else begin
            reg_addr_o  = low_idx;
            mem_addr_o  = addr_q;
            uop_valid_o = issue;
            reg_write_o = issue & is_lm_q;
            mem_write_o = issue & !is_lm_q;
            // Release the stall in the final issue cycle so the next
            // instruction advances alongside done.
            stall_out_o = !(issue & last);
            if (issue) begin
                rem_mask_d = rem_mask_q & ~low_bit;
                addr_d     = addr_q + 1'b1;
                if (last) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
        end

        if (flush_i) begin
            state_d    = IDLE;
            rem_mask_d = 8'h00;
        end

        if (!rst_n_i) begin
            stall_out_o = 1'b0;
            uop_valid_o = 1'b0;
            reg_addr_o  = '0;
            mem_addr_o  = '0;
            reg_write_o = 1'b0;
            mem_write_o = 1'b0;
            done_o      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            rem_mask_q <= 8'h00;
            addr_q     <= '0;
            is_lm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_mask_q <= rem_mask_d;
            addr_q     <= addr_d;
            is_lm_q    <= is_lm_d;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [7:0]  reg_mask = 8'h00;
    logic [15:0] base_addr = 16'h0000;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        stall_out, uop_valid, reg_write, mem_write, done;
    logic [2:0]  reg_addr;
    logic [15:0] mem_addr;

    int applied = 0;
    int miscompares = 0;

    lm_sm_sequencer #(.ADDR_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .instr_valid_i(instr_valid), .op_i(op),
        .reg_mask_i(reg_mask), .base_addr_i(base_addr), .hold_i(hold),
        .flush_i(flush), .stall_out_o(stall_out), .uop_valid_o(uop_valid),
        .reg_addr_o(reg_addr), .mem_addr_o(mem_addr), .reg_write_o(reg_write),
        .mem_write_o(mem_write), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, iv;
        logic [3:0]  op;
        logic [7:0]  m;
        logic [15:0] b;
        logic        h, f;
        logic        es, eu;
        logic [2:0]  era;
        logic [15:0] ema;
        logic        erw, emw, ed;
        string       name;
    } vec_t;

    vec_t vq[$];

    task automatic v(input string n, input logic r, input logic iv, input logic [3:0] o,
                     input logic [7:0] m, input logic [15:0] b, input logic h, input logic f,
                     input logic es, input logic eu, input logic [2:0] era,
                     input logic [15:0] ema, input logic erw, input logic emw, input logic ed);
        vec_t t;
        t.name = n; t.r = r; t.iv = iv; t.op = o; t.m = m; t.b = b; t.h = h; t.f = f;
        t.es = es; t.eu = eu; t.era = era; t.ema = ema; t.erw = erw; t.emw = emw; t.ed = ed;
        vq.push_back(t);
    endtask

    task automatic idle(input string n);
        v(n, 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
    endtask

    function automatic logic [23:0] pack_out();
        return {stall_out, uop_valid, reg_addr, mem_addr, reg_write, mem_write, done};
    endfunction

    initial begin
        logic [23:0] exp_o, act_o;
        int uops;
        int waited;
        bit got_done;

        // Reset
        v("reset0", 0, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        v("reset1", 0, 1, 4'h6, 8'hFF, 16'h1234, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        idle("idle0");
        // LM A5 @0040; an SM presented mid-run must be ignored
        v("lm_a5_start", 1, 1, 4'h6, 8'hA5, 16'h0040, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 0);
        v("lm_a5_u0", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 1, 1, 3'd0, 16'h0040, 1, 0, 0);
        v("lm_a5_u1", 1, 1, 4'h7, 8'hFF, 16'h9999, 0, 0, 1, 1, 3'd2, 16'h0041, 1, 0, 0);
        v("lm_a5_u2", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 1, 1, 3'd5, 16'h0042, 1, 0, 0);
        v("lm_a5_u3", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, 1, 3'd7, 16'h0043, 1, 0, 1);
        idle("lm_a5_after");
        // SM 80 @FFFF then back-to-back start with fresh base
        v("sm_80_start", 1, 1, 4'h7, 8'h80, 16'hFFFF, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 0);
        v("sm_80_u0", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, 1, 3'd7, 16'hFFFF, 0, 1, 1);
        v("sm_01_start", 1, 1, 4'h7, 8'h01, 16'h1234, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 0);
        v("sm_01_u0", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, 1, 3'd0, 16'h1234, 0, 1, 1);
        // SM FF @FFFE, address wrap
        v("sm_ff_start", 1, 1, 4'h7, 8'hFF, 16'hFFFE, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            v($sformatf("sm_ff_u%0d", i), 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0,
              (i != 7), 1, 3'(i), 16'(16'hFFFE + i), 0, 1, (i == 7));
        idle("sm_ff_after");
        // Empty mask, non-LM/SM opcode, hold on start
        v("lm_00", 1, 1, 4'h6, 8'h00, 16'h1111, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 1);
        idle("lm_00_after");
        v("bad_op", 1, 1, 4'h5, 8'hFF, 16'h2222, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        idle("bad_op_after");
        v("hold_start", 1, 1, 4'h6, 8'h0F, 16'h0100, 1, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        idle("hold_start_after");
        // LM 0F with hold on 2nd RUN cycle
        v("lm_0f_start", 1, 1, 4'h6, 8'h0F, 16'h0100, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 0);
        v("lm_0f_u0", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 1, 1, 3'd0, 16'h0100, 1, 0, 0);
        v("lm_0f_hold", 1, 0, 4'h0, 8'h00, 16'h0000, 1, 0, 1, 0, 3'd1, 16'h0101, 0, 0, 0);
        v("lm_0f_u1", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 1, 1, 3'd1, 16'h0101, 1, 0, 0);
        v("lm_0f_u2", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 1, 1, 3'd2, 16'h0102, 1, 0, 0);
        v("lm_0f_u3", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, 1, 3'd3, 16'h0103, 1, 0, 1);
        // Flush on 3rd RUN cycle
        v("fl_start", 1, 1, 4'h7, 8'hFF, 16'h0200, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 0);
        v("fl_u0", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 1, 1, 3'd0, 16'h0200, 0, 1, 0);
        v("fl_u1", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 1, 1, 3'd1, 16'h0201, 0, 1, 0);
        v("fl_kill", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 1, 1, 0, 3'd2, 16'h0202, 0, 0, 0);
        idle("fl_after0");
        idle("fl_after1");
        // Flush coincident with start
        v("fl_on_start", 1, 1, 4'h6, 8'hFF, 16'h0300, 0, 1, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        idle("fl_on_start_after");
        // Reset mid-RUN, then a clean restart
        v("rst_start", 1, 1, 4'h6, 8'h03, 16'h0400, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 0);
        v("rst_u0", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 1, 1, 3'd0, 16'h0400, 1, 0, 0);
        v("rst_mid", 0, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
        idle("rst_after");
        v("re_start", 1, 1, 4'h6, 8'h01, 16'h0500, 0, 0, 1, 0, 3'd0, 16'h0000, 0, 0, 0);
        v("re_u0", 1, 0, 4'h0, 8'h00, 16'h0000, 0, 0, 0, 1, 3'd0, 16'h0500, 1, 0, 1);

        foreach (vq[k]) begin
            @(negedge clk);
            rst_n = vq[k].r; instr_valid = vq[k].iv; op = vq[k].op; reg_mask = vq[k].m;
            base_addr = vq[k].b; hold = vq[k].h; flush = vq[k].f;
            #1;
            exp_o = {vq[k].es, vq[k].eu, vq[k].era, vq[k].ema, vq[k].erw, vq[k].emw, vq[k].ed};
            act_o = pack_out();
            applied++;
            if (act_o !== exp_o) begin
                miscompares++;
                $display("FAIL %s: got {stall,uv,ra,ma,rw,mw,done}=%h expected %h",
                         vq[k].name, act_o, exp_o);
            end
        end

        // SM 55 @0600 with hold on alternate cycles; expect R0,R2,R4,R6 at 0600..0603
        @(negedge clk);
        rst_n = 1; instr_valid = 1; op = 4'h7; reg_mask = 8'h55; base_addr = 16'h0600;
        hold = 0; flush = 0;
        @(negedge clk);
        instr_valid = 0;
        uops = 0; waited = 0; got_done = 0;
        while (!got_done && waited < 40) begin
            hold = waited[0];
            #1;
            if (uop_valid) begin
                applied++;
                exp_o = {1'b0, 1'b1, 3'(2 * uops), 16'(16'h0600 + uops), 1'b0, 1'b1, 1'b0};
                act_o = {1'b0, uop_valid, reg_addr, mem_addr, reg_write, mem_write, 1'b0};
                if (act_o !== exp_o) begin
                    miscompares++;
                    $display("FAIL sm55_uop%0d: got %h expected %h", uops, act_o, exp_o);
                end
                uops++;
            end
            if (done) begin
                got_done = 1;
                applied++;
                if (uops != 4 || stall_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sm55_done: uops=%0d stall=%b expected uops=4 stall=0",
                             uops, stall_out);
                end
            end
            waited++;
            @(negedge clk);
        end
        hold = 0;
        if (!got_done) begin
            applied++;
            miscompares++;
            $display("FAIL sm55_timeout: no done after %0d cycles, uops=%0d", waited, uops);
        end
        // Hold alternates starting issue-first, so 4 uops take 7 RUN cycles.
        applied++;
        if (waited != 7) begin
            miscompares++;
            $display("FAIL sm55_cycles: got %0d RUN cycles expected 7", waited);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-cycle sequencer for the Load-Multiple (LM, op 4'b0110) and Store-Multiple (SM, op 4'b0111) instructions of the 6-stage pipeline. It accepts one LM/SM from the decode stage and expands its 8-bit register mask into one register/memory micro-op per cycle. Transfers run in ascending register order, at consecutive word addresses from a base address. While it runs, it stalls the upstream stages. It drives the register-file write request for LM and the memory write request for SM.

## Interface
- ADDR_W, 16, memory address width
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- instr_valid  input  1  decode stage presents a valid instruction this cycle
- op  input  4  opcode of presented instruction
- reg_mask  input  8  LM/SM immediate; bit i set = transfer register Ri
- base_addr  input  ADDR_W  start address (value of base register RA)
- hold  input  1  downstream stall; freezes the sequencer for this cycle
- flush  input  1  invalidate in-flight instruction (branch/jump mispredict)
- stall_out  output  1  hold fetch/decode; do not present a new instruction
- uop_valid  output  1  a micro-op is issued this cycle
- reg_addr  output  3  register index of the issued micro-op (LM write dest / SM read src)
- mem_addr  output  ADDR_W  memory address of the issued micro-op
- reg_write  output  1  uop_valid & LM: register-file write request
- mem_write  output  1  uop_valid & SM: memory write request
- done  output  1  one-cycle pulse: LM/SM retires this cycle

## Operation
- State: IDLE, RUN. Internal registers: rem_mask[7:0], addr[ADDR_W-1:0], is_lm.
- Start condition: state==IDLE & instr_valid & (op==4'b0110 | op==4'b0111) & !hold & !flush.
- On start with reg_mask!=0: rem_mask<=reg_mask, addr<=base_addr, is_lm<=(op==4'b0110), next state RUN.
- On start with reg_mask==0: stay IDLE, assert done in the same cycle, issue no micro-op, stall_out=0.
- RUN: reg_addr = index of lowest set bit of rem_mask. mem_addr = addr. uop_valid = !hold & !flush.
- RUN, issuing (uop_valid=1): clear that bit of rem_mask and set addr<=addr+1, wrapping modulo 2^ADDR_W.
- If the issued bit was the last set bit: done=1, next state IDLE.
- RUN with hold=1: no issue, all registers unchanged, done=0.
- flush=1 in any state: next state IDLE, rem_mask<=0. uop_valid, reg_write, mem_write and done are forced 0 that cycle. flush wins over start and hold.
- Non-LM/SM opcodes and instructions presented while in RUN are ignored.
- reg_write = uop_valid & is_lm. mem_write = uop_valid & !is_lm.

## Timing
- Reset (rst_n=0 at edge): state IDLE, rem_mask 0, addr 0, is_lm 0.
- While rst_n=0, all outputs are forced 0.
- Latency: the first micro-op issues in the cycle after the start cycle.
- An N-bit mask occupies N RUN cycles plus the hold cycles; total start-to-done is N+1 cycles with no hold.
- stall_out is combinational and asserted in two cases:
  - in the start cycle when reg_mask!=0;
  - in every RUN cycle except a non-held, non-flushed cycle issuing the final bit.
- So the next instruction advances in the same cycle as done.
- A new start is accepted in the cycle after returning to IDLE.
- All micro-op outputs are combinational from the registered state, gated by hold/flush. The consumer samples them on the same clock edge.

## Test plan
- LM, mask=8'b1010_0101, base=16'h0040, no hold:
  - uops (R0,0040), (R2,0041), (R5,0042), (R7,0043) on cycles 1–4, reg_write=1 each;
  - done on cycle 4; stall_out high on cycles 0–3, low on cycle 4.
- SM, mask=8'h80, base=16'hFFFF: single uop (R7,FFFF), mem_write=1, done with it. A following start latches the new base, with no leftover address state.
- SM, mask=8'hFF, base=16'hFFFE: addresses FFFE, FFFF, 0000 … 0005 (wrap); 8 uops, mem_write=1, reg_write=0.
- LM, mask=8'h00: done in the start cycle, no uop_valid, stall_out never asserted, state stays IDLE.
- LM, mask=8'h0F with hold high on the 2nd RUN cycle: that cycle has uop_valid=0 and the same reg_addr/mem_addr. The sequence resumes at R1 and done arrives one cycle later.
- Two flush cases:
  - flush on the 3rd RUN cycle of mask=8'hFF: no uop or done that cycle, IDLE next, stall_out low, R2+ never issued;
  - flush coincident with start: nothing accepted.
- rst_n low mid-RUN: outputs 0 immediately, IDLE after the edge, no done.
